// File: rtl/dcpu_mem_responder.sv
// rtl/dcpu_mem_responder.sv - dcpu memory bus target: sync RAM behind a programmable wait-state handshake
// Optional write protection of the low words is enabled with DCPU_MEM_WPROT_EN.
module dcpu_mem_responder #(
  parameter int W           = 16,
  parameter int AW          = 10,
  parameter int WAIT_STATES = 1,
  parameter int WPROT_TOP   = 64
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_cs,
  input  logic         i_we,
  input  logic [W-1:0] i_addr,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_ack,
  output logic         o_wprot_err
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("dcpu_mem_responder: WAIT_STATES must be in 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t         state, state_next;
  logic [3:0]     cnt, cnt_next;
  logic [AW-1:0]  addr_q;
  logic           we_q;
  logic [W-1:0]   dat_q;
  logic [W-1:0]   mem [0:(1<<AW)-1];

  logic [AW-1:0]  acc_addr;
  logic           acc_we;
  logic [W-1:0]   acc_dat;
  logic           enter_ack;
  logic           blocked;
  logic           ram_wr;
  logic           unused_addr_hi;

  assign unused_addr_hi = ^i_addr[W-1:AW];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (i_cs) begin
          if (WAIT_STATES == 0) begin
            state_next = S_ACK;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!i_cs) begin
          state_next = S_IDLE;
        end else if (cnt == 4'd0) begin
          state_next = S_ACK;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the access completes straight from IDLE, so the live bus is used.
  assign acc_addr  = (state == S_IDLE) ? i_addr[AW-1:0] : addr_q;
  assign acc_we    = (state == S_IDLE) ? i_we : we_q;
  assign acc_dat   = (state == S_IDLE) ? i_dat : dat_q;
  assign enter_ack = (state_next == S_ACK);

`ifdef DCPU_MEM_WPROT_EN
  assign blocked = acc_we && (32'(acc_addr) < WPROT_TOP);
`else
  localparam int unused_wprot_top = WPROT_TOP;
  assign blocked = 1'b0;
`endif

  assign ram_wr = enter_ack && acc_we && !blocked && !i_reset;
  assign o_ack  = (state == S_ACK);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      o_dat <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (enter_ack) begin
        o_dat <= (acc_we && !blocked) ? acc_dat : mem[acc_addr];
      end
    end
  end

`ifdef DCPU_MEM_WPROT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wprot_err <= 1'b0;
    end else begin
      o_wprot_err <= enter_ack && blocked;
    end
  end
`else
  assign o_wprot_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (state == S_IDLE && i_cs) begin
      addr_q <= i_addr[AW-1:0];
      we_q   <= i_we;
      dat_q  <= i_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ram_wr) begin
      mem[acc_addr] <= acc_dat;
    end
  end

endmodule

// File: tb/tb_dcpu_mem_responder.sv
// tb/tb_dcpu_mem_responder.sv - directed assertion bench for dcpu_mem_responder at 1, 0 and 3 wait states
module tb_dcpu_mem_responder;

  logic        i_clk;
  logic        i_reset;
  logic        cs   [3];
  logic        we   [3];
  logic [15:0] addr [3];
  logic [15:0] wdat [3];
  logic [15:0] rdat [3];
  logic        ack  [3];
  logic        werr [3];

  int n_assert;
  int n_fail;

  dcpu_mem_responder #(.W(16), .AW(10), .WAIT_STATES(1), .WPROT_TOP(64)) u_ws1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_cs(cs[0]), .i_we(we[0]), .i_addr(addr[0]),
    .i_dat(wdat[0]), .o_dat(rdat[0]), .o_ack(ack[0]), .o_wprot_err(werr[0]));

  dcpu_mem_responder #(.W(16), .AW(10), .WAIT_STATES(0), .WPROT_TOP(64)) u_ws0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_cs(cs[1]), .i_we(we[1]), .i_addr(addr[1]),
    .i_dat(wdat[1]), .o_dat(rdat[1]), .o_ack(ack[1]), .o_wprot_err(werr[1]));

  dcpu_mem_responder #(.W(16), .AW(10), .WAIT_STATES(3), .WPROT_TOP(64)) u_ws3 (
    .i_clk(i_clk), .i_reset(i_reset), .i_cs(cs[2]), .i_we(we[2]), .i_addr(addr[2]),
    .i_dat(wdat[2]), .o_dat(rdat[2]), .o_ack(ack[2]), .o_wprot_err(werr[2]));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus cycle on instance k; lat is the number of rising edges until o_ack (0 = timed out).
  task automatic access(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int lat, output logic err);
    cs[k] = 1'b1; we[k] = w; addr[k] = a; wdat[k] = d;
    lat = 0; rd = '0; err = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge i_clk); #1;
      if (ack[k]) begin
        lat = n; rd = rdat[k]; err = werr[k];
        break;
      end
    end
    cs[k] = 1'b0; we[k] = 1'b0;
    if (lat == 0) check("access_timeout", 32'(lat), 32'd1);
    @(posedge i_clk); #1;
  endtask

  logic [15:0] rd, v0;
  int          lat, nack, last_cyc, idx;
  logic        err;
  logic [15:0] exp_b2b [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0; n_fail = 0;
    for (int k = 0; k < 3; k++) begin
      cs[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdat[k] = '0;
    end
    i_reset = 1'b1;
    #2;
    check("reset_ack",  32'(ack[0]),  32'd0);
    check("reset_dat",  32'(rdat[0]), 32'd0);
    check("reset_werr", 32'(werr[0]), 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // One wait state: write then read back
    access(0, 1'b1, 16'h0100, 16'hBEEF, rd, lat, err);
    check("ws1_write_lat",  32'(lat), 32'd2);
    check("ws1_write_echo", 32'(rd),  32'hBEEF);
    access(0, 1'b0, 16'h0100, 16'h0000, rd, lat, err);
    check("ws1_read_lat",  32'(lat), 32'd2);
    check("ws1_read_data", 32'(rd),  32'hBEEF);
    check("ack_one_cycle", 32'(ack[0]), 32'd0);

    // Address aliasing above 2^AW
    access(0, 1'b1, 16'h0405, 16'h1234, rd, lat, err);
    access(0, 1'b0, 16'h0005, 16'h0000, rd, lat, err);
    check("wrap_read_data", 32'(rd), 32'h1234);

    // Zero wait states: preload, then three reads with i_cs held
    exp_b2b[0] = 16'h1111; exp_b2b[1] = 16'h2222; exp_b2b[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      access(1, 1'b1, 16'(i + 1), exp_b2b[i], rd, lat, err);
      check("ws0_write_lat", 32'(lat), 32'd1);
    end
    cs[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0001;
    nack = 0; last_cyc = 0; idx = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge i_clk); #1;
      if (ack[1]) begin
        nack++;
        if (idx < 3) check("b2b_data", 32'(rdat[1]), 32'(exp_b2b[idx]));
        if (idx > 0) check("b2b_spacing", 32'(c - last_cyc), 32'd2);
        last_cyc = c;
        idx++;
        if (idx < 3) addr[1] = 16'(idx + 1);
        else cs[1] = 1'b0;
      end
    end
    cs[1] = 1'b0;
    check("b2b_ack_count", 32'(nack), 32'd3);

    // Three wait states: preload, then a read whose inputs change during WAIT
    access(2, 1'b1, 16'h0200, 16'h5A5A, rd, lat, err);
    check("ws3_write_lat", 32'(lat), 32'd4);
    cs[2] = 1'b1; we[2] = 1'b0; addr[2] = 16'h0200;
    @(posedge i_clk); #1;
    we[2] = 1'b1; addr[2] = 16'h0201; wdat[2] = 16'hFFFF;
    lat = 0;
    for (int n = 2; n <= 20; n++) begin
      @(posedge i_clk); #1;
      if (ack[2]) begin lat = n; rd = rdat[2]; break; end
    end
    cs[2] = 1'b0; we[2] = 1'b0;
    @(posedge i_clk); #1;
    check("captured_lat",  32'(lat), 32'd4);
    check("captured_data", 32'(rd),  32'h5A5A);
    access(2, 1'b0, 16'h0201, 16'h0000, rd, lat, err);
    check("captured_no_write", 32'(rd == 16'hFFFF), 32'd0);

    // Abort: drop i_cs while waiting
    cs[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0200; wdat[2] = 16'hDEAD;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    cs[2] = 1'b0; we[2] = 1'b0;
    nack = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge i_clk); #1;
      if (ack[2]) nack++;
    end
    check("abort_no_ack", 32'(nack), 32'd0);
    access(2, 1'b0, 16'h0200, 16'h0000, rd, lat, err);
    check("abort_readback", 32'(rd), 32'h5A5A);

    // Asynchronous reset in the middle of WAIT
    cs[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0200; wdat[2] = 16'hBAD0;
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    #1;
    check("rst_wait_ack",     32'(ack[2]),  32'd0);
    check("rst_wait_dat",     32'(rdat[2]), 32'd0);
    check("rst_other_dat",    32'(rdat[0]), 32'd0);
    cs[2] = 1'b0; we[2] = 1'b0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    access(2, 1'b0, 16'h0200, 16'h0000, rd, lat, err);
    check("rst_readback", 32'(rd), 32'h5A5A);
    access(0, 1'b0, 16'h0100, 16'h0000, rd, lat, err);
    check("rst_ram_intact", 32'(rd), 32'hBEEF);

`ifdef DCPU_MEM_WPROT_EN
    access(0, 1'b0, 16'h0010, 16'h0000, v0, lat, err);
    check("wprot_read_err", 32'(err), 32'd0);
    access(0, 1'b1, 16'h0010, 16'hAAAA, rd, lat, err);
    check("wprot_block_lat", 32'(lat), 32'd2);
    check("wprot_block_err", 32'(err), 32'd1);
    check("wprot_block_dat", 32'(rd),  32'(v0));
    access(0, 1'b0, 16'h0010, 16'h0000, rd, lat, err);
    check("wprot_unchanged", 32'(rd), 32'(v0));
    access(0, 1'b1, 16'h0040, 16'h4444, rd, lat, err);
    check("wprot_top_err",  32'(err), 32'd0);
    access(0, 1'b0, 16'h0040, 16'h0000, rd, lat, err);
    check("wprot_top_commit", 32'(rd), 32'h4444);
`else
    v0 = 16'h0000;
    access(0, 1'b1, 16'h0010, 16'hAAAA, rd, lat, err);
    check("nowprot_err",  32'(err), 32'd0);
    check("nowprot_echo", 32'(rd),  32'hAAAA);
    access(0, 1'b0, 16'h0010, 16'h0000, rd, lat, err);
    check("nowprot_commit", 32'(rd), 32'hAAAA);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
